// File: rtl/vga_line_fill_ctrl.sv
// vga_line_fill_ctrl: fetches framebuffer lines over an AXI read master and
// writes them alternately into two line-buffer banks for the VGA scanout.
//
// state | meaning
// ------+-----------------------------------------------------------------
// WAIT  | idle; waits for the display to be ready and the target bank free
// REQ   | line_req held high with a stable line_addr until line_ack
// FILL  | s_ready high; each accepted beat is written one cycle later
`timescale 1ns/1ps

module vga_line_fill_ctrl #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH    = 32,
    parameter int LINE_WORDS         = 640,
    parameter int LINES              = 480,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] FB_BASE = 32'h1000_0000
) (
    input  logic                          vga_clk,
    input  logic                          rst_n,
    input  logic                          vga_ready,
    output logic                          axi_vga_ready,
    output logic                          line_req,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] line_addr,
    input  logic                          line_ack,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    output logic [BRAM_ADDR_WIDTH-1:0]    waddr_1,
    output logic [C_M_AXI_DATA_WIDTH-1:0] wdata_1,
    output logic                          wren_1,
    output logic [BRAM_ADDR_WIDTH-1:0]    waddr_2,
    output logic [C_M_AXI_DATA_WIDTH-1:0] wdata_2,
    output logic                          wren_2,
    input  logic                          release_1,
    input  logic                          release_2,
    output logic                          fill_err
);

    localparam int WW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);
    // Byte stride between consecutive lines in the framebuffer.
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] LINE_BYTES =
        C_M_AXI_ADDR_WIDTH'(LINE_WORDS * (C_M_AXI_DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2
    } state_t;

    state_t                          state_q;
    logic                            tgt_q;        // 0: bank 1, 1: bank 2
    logic [LW-1:0]                   line_q;
    logic [WW-1:0]                   word_q;
    // Running line base address avoids a multiplier on the request path.
    logic [C_M_AXI_ADDR_WIDTH-1:0]   line_base_q;
    logic                            full_1_q, full_2_q;
    logic                            line_req_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   line_addr_q;
    logic                            s_ready_q;
    logic [BRAM_ADDR_WIDTH-1:0]      waddr_1_q, waddr_2_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_1_q, wdata_2_q;
    logic                            wren_1_q, wren_2_q;
    logic                            fill_err_q;
    logic                            axi_vga_ready_q;

    logic accept, last_word, complete;
    logic full_1_d, full_2_d;

    // Beat acceptance, line completion and next bank-full flags; a release
    // and a completion into the other bank both take effect in one cycle.
    always_comb begin
        accept    = s_ready_q & s_valid;
        last_word = (word_q == LAST_WORD);
        complete  = accept & (last_word | s_last);
        full_1_d  = full_1_q & ~release_1;
        full_2_d  = full_2_q & ~release_2;
        if (complete) begin
            if (tgt_q) full_2_d = 1'b1;
            else       full_1_d = 1'b1;
        end
    end

    // Sequencer FSM, bank bookkeeping and registered outputs.
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            state_q         <= S_WAIT;
            tgt_q           <= 1'b0;
            line_q          <= '0;
            word_q          <= '0;
            line_base_q     <= FB_BASE;
            full_1_q        <= 1'b0;
            full_2_q        <= 1'b0;
            line_req_q      <= 1'b0;
            line_addr_q     <= '0;
            s_ready_q       <= 1'b0;
            waddr_1_q       <= '0;
            waddr_2_q       <= '0;
            wdata_1_q       <= '0;
            wdata_2_q       <= '0;
            wren_1_q        <= 1'b0;
            wren_2_q        <= 1'b0;
            fill_err_q      <= 1'b0;
            axi_vga_ready_q <= 1'b0;
        end else begin
            wren_1_q <= 1'b0;
            wren_2_q <= 1'b0;
            full_1_q <= full_1_d;
            full_2_q <= full_2_d;
            if (full_1_d && full_2_d) begin
                axi_vga_ready_q <= 1'b1;
            end

            if (accept) begin
                if (tgt_q) begin
                    wren_2_q  <= 1'b1;
                    waddr_2_q <= BRAM_ADDR_WIDTH'(word_q);
                    wdata_2_q <= s_data;
                end else begin
                    wren_1_q  <= 1'b1;
                    waddr_1_q <= BRAM_ADDR_WIDTH'(word_q);
                    wdata_1_q <= s_data;
                end
                // Burst length disagrees with the expected line length.
                if (s_last != last_word) begin
                    fill_err_q <= 1'b1;
                end
            end

            case (state_q)
                S_WAIT: begin
                    if (vga_ready && !(tgt_q ? full_2_q : full_1_q)) begin
                        state_q     <= S_REQ;
                        line_req_q  <= 1'b1;
                        line_addr_q <= line_base_q;
                    end
                end
                S_REQ: begin
                    if (line_ack) begin
                        state_q    <= S_FILL;
                        line_req_q <= 1'b0;
                        s_ready_q  <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (complete) begin
                        state_q   <= S_WAIT;
                        s_ready_q <= 1'b0;
                        word_q    <= '0;
                        tgt_q     <= ~tgt_q;
                        if (line_q == LAST_LINE) begin
                            line_q      <= '0;
                            line_base_q <= FB_BASE;
                        end else begin
                            line_q      <= line_q + 1'b1;
                            line_base_q <= line_base_q + LINE_BYTES;
                        end
                    end else if (accept) begin
                        word_q <= word_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_WAIT;
                end
            endcase
        end
    end

    assign axi_vga_ready = axi_vga_ready_q;
    assign line_req      = line_req_q;
    assign line_addr     = line_addr_q;
    assign s_ready       = s_ready_q;
    assign waddr_1       = waddr_1_q;
    assign wdata_1       = wdata_1_q;
    assign wren_1        = wren_1_q;
    assign waddr_2       = waddr_2_q;
    assign wdata_2       = wdata_2_q;
    assign wren_2        = wren_2_q;
    assign fill_err      = fill_err_q;

endmodule
